// File: rtl/posit_normalise_pipe_pkg.sv
// Shared constants, width helpers and the stage-1 register type for the
// pipelined posit normaliser.
package posit_pkg;

  // Upper bounds for the parameter-independent stage-1 record. Instances use
  // the low WIDTH / SW bits of these fields. The frac field is zero-extended
  // and the scale field is sign-extended into the spare bits.
  localparam int unsigned FRAC_MAX_W  = 64;
  localparam int unsigned SCALE_MAX_W = 32;

  // Width of a leading-zero count that can represent 0..width.
  function automatic int unsigned lz_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Width at which regime*2^ES + exponent + 1 - lz cannot overflow.
  function automatic int unsigned scale_width(input int unsigned rw,
                                              input int unsigned es,
                                              input int unsigned ew,
                                              input int unsigned width);
    return (((rw + es) > ew) ? (rw + es) : ew) + lz_width(width) + 2;
  endfunction

  // Largest regime magnitude representable in a posit of pbits bits.
  function automatic int rmax(input int pbits);
    return pbits - 2;
  endfunction

  // Zero is encoded with only the regime MSB set. Callers slice the low rw bits.
  function automatic logic [SCALE_MAX_W-1:0] zero_regime(input int unsigned rw);
    return SCALE_MAX_W'(1) << (rw - 1);
  endfunction

  typedef struct packed {
    logic [FRAC_MAX_W-1:0]         frac;
    logic signed [SCALE_MAX_W-1:0] scale;
    logic                          zero;
    logic                          nar;
  } norm_s1_t;

endpackage

// File: rtl/posit_normalise_pipe_if.sv
// Valid/ready bus between the mantissa-add stage, the normaliser and the encoder.
interface posit_normalise_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ES    = 1,
  parameter int unsigned RW    = 8,
  parameter int unsigned EW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant_sum;
  logic [RW-1:0]    in_regime;
  logic [EW-1:0]    in_exponent;
  logic             in_nar;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_frac;
  logic [RW-1:0]    out_regime;
  logic [ES-1:0]    out_exponent;
  logic             out_zero;
  logic             out_nar;
  logic             out_ovf;
  logic             out_unf;

  // Environment view: feeds beats in and consumes results.
  modport master (
    output in_valid, in_mant_sum, in_regime, in_exponent, in_nar, out_ready,
    input  in_ready, out_valid, out_frac, out_regime, out_exponent,
           out_zero, out_nar, out_ovf, out_unf
  );

  // Normaliser view.
  modport slave (
    input  in_valid, in_mant_sum, in_regime, in_exponent, in_nar, out_ready,
    output in_ready, out_valid, out_frac, out_regime, out_exponent,
           out_zero, out_nar, out_ovf, out_unf
  );
endinterface

// File: rtl/posit_normalise_pipe_lzc.sv
// Priority leading-zero counter. An all-zero input returns WIDTH.
module count_lead_zero_p
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]           in_vec,
  output logic [lz_width(WIDTH)-1:0] lz_count
);
  localparam int unsigned LZW = lz_width(WIDTH);

  // Scan upward so that the highest set bit is the last one to write the count.
  always_comb begin
    lz_count = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) begin
        lz_count = LZW'(WIDTH - 1 - i);
      end
    end
  end
endmodule

// File: rtl/posit_normalise_pipe.sv
// Two-stage normaliser for the posit adder. Stage 1 finds the leading one and
// forms the combined scale. Stage 2 re-splits that scale into regime and
// exponent, saturates the regime, and applies the zero/NaR overrides.
module posit_normalise_pipe
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ES    = 1,
  parameter int unsigned RW    = 8,
  parameter int unsigned EW    = 8,
  parameter int unsigned PBITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit_normalise_pipe_if.slave bus
);
  localparam int unsigned LZW = lz_width(WIDTH);
  localparam int unsigned SW  = scale_width(RW, ES, EW, WIDTH);
  localparam int          RMAX = rmax(PBITS);
  localparam logic [RW-1:0] ZERO_REGIME = RW'(zero_regime(RW));
  localparam logic [RW-1:0] REGIME_MAX  = RW'(RMAX);
  localparam logic [RW-1:0] REGIME_MIN  = RW'(-RMAX);
  localparam logic signed [SCALE_MAX_W-1:0] R_HI = SCALE_MAX_W'(RMAX);
  localparam logic signed [SCALE_MAX_W-1:0] R_LO = SCALE_MAX_W'(-RMAX);

  logic s1_adv;
  logic s2_adv;

  logic [LZW-1:0]        lz;
  logic [WIDTH-1:0]      norm_mant;
  logic signed [SW-1:0]  scale;
  norm_s1_t              s1_new;
  norm_s1_t              s1_d;
  norm_s1_t              s1_q;
  logic                  s1_valid_d;
  logic                  s1_valid_q;

  logic signed [SCALE_MAX_W-1:0] r;
  logic             out_valid_d,    out_valid_q;
  logic [WIDTH-1:0] out_frac_d,     out_frac_q;
  logic [RW-1:0]    out_regime_d,   out_regime_q;
  logic [ES-1:0]    out_exponent_d, out_exponent_q;
  logic             out_zero_d,     out_zero_q;
  logic             out_nar_d,      out_nar_q;
  logic             out_ovf_d,      out_ovf_q;
  logic             out_unf_d,      out_unf_q;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  count_lead_zero_p #(.WIDTH(WIDTH)) u_lzc (
    .in_vec   (bus.in_mant_sum),
    .lz_count (lz)
  );

  // Stage 1: normalise the mantissa and form the scale at a width that cannot overflow.
  always_comb begin
    norm_mant = bus.in_mant_sum << lz;
    scale = (SW'($signed(bus.in_regime)) <<< ES) + SW'($signed(bus.in_exponent))
          + SW'(1) - SW'(lz);
    s1_new.frac  = FRAC_MAX_W'(norm_mant << 1);
    s1_new.scale = SCALE_MAX_W'(scale);
    s1_new.zero  = (bus.in_mant_sum == '0);
    s1_new.nar   = bus.in_nar;
    s1_valid_d   = s1_adv ? bus.in_valid : s1_valid_q;
    s1_d         = (s1_adv && bus.in_valid) ? s1_new : s1_q;
  end

  // Stage 1 register: holds its beat while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Stage 2: floor-split the scale, then apply overrides (nar > zero > ovf/unf).
  always_comb begin
    r              = $signed(s1_q.scale) >>> ES;
    out_valid_d    = out_valid_q;
    out_frac_d     = out_frac_q;
    out_regime_d   = out_regime_q;
    out_exponent_d = out_exponent_q;
    out_zero_d     = out_zero_q;
    out_nar_d      = out_nar_q;
    out_ovf_d      = out_ovf_q;
    out_unf_d      = out_unf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_frac_d     = s1_q.frac[WIDTH-1:0];
        out_regime_d   = r[RW-1:0];
        out_exponent_d = s1_q.scale[ES-1:0];
        out_zero_d     = 1'b0;
        out_nar_d      = 1'b0;
        out_ovf_d      = 1'b0;
        out_unf_d      = 1'b0;
        if (s1_q.nar) begin
          out_frac_d     = '0;
          out_regime_d   = '0;
          out_exponent_d = '0;
          out_nar_d      = 1'b1;
        end else if (s1_q.zero) begin
          out_frac_d     = '0;
          out_regime_d   = ZERO_REGIME;
          out_exponent_d = '0;
          out_zero_d     = 1'b1;
        end else if (r > R_HI) begin
          out_frac_d     = '0;
          out_regime_d   = REGIME_MAX;
          out_exponent_d = '0;
          out_ovf_d      = 1'b1;
        end else if (r < R_LO) begin
          out_frac_d     = '0;
          out_regime_d   = REGIME_MIN;
          out_exponent_d = '0;
          out_unf_d      = 1'b1;
        end
      end
    end
  end

  // Stage 2 register: outputs stay frozen until the downstream accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_frac_q     <= '0;
      out_regime_q   <= '0;
      out_exponent_q <= '0;
      out_zero_q     <= 1'b0;
      out_nar_q      <= 1'b0;
      out_ovf_q      <= 1'b0;
      out_unf_q      <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_frac_q     <= out_frac_d;
      out_regime_q   <= out_regime_d;
      out_exponent_q <= out_exponent_d;
      out_zero_q     <= out_zero_d;
      out_nar_q      <= out_nar_d;
      out_ovf_q      <= out_ovf_d;
      out_unf_q      <= out_unf_d;
    end
  end

  // The frac field is wider than WIDTH. Its upper bits are always zero.
  generate
    if (WIDTH < FRAC_MAX_W) begin : g_frac_pad
      logic unused_frac_pad;
      assign unused_frac_pad = ^s1_q.frac[FRAC_MAX_W-1:WIDTH];
    end
  endgenerate

  assign bus.out_valid    = out_valid_q;
  assign bus.out_frac     = out_frac_q;
  assign bus.out_regime   = out_regime_q;
  assign bus.out_exponent = out_exponent_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_nar      = out_nar_q;
  assign bus.out_ovf      = out_ovf_q;
  assign bus.out_unf      = out_unf_q;
endmodule

// File: tb/tb_posit_normalise_pipe.sv
// Directed bench for posit_normalise_pipe at the default parameters (RMAX = 6).
// Results are packed as {frac[8], regime[8], exp[1], nar, zero, ovf, unf}.
module tb_posit_normalise_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ES    = 1;
  localparam int unsigned RW    = 8;
  localparam int unsigned EW    = 8;
  localparam int unsigned PBITS = 8;
  localparam int NV = 13;

  // Directed vectors: mant, regime, exponent, nar, expected packed result.
  localparam logic [7:0] TV_MANT [NV] = '{8'h60, 8'hA0, 8'h08, 8'h50, 8'h30,
                                          8'h00, 8'h40, 8'h00, 8'h00,
                                          8'h80, 8'h01, 8'h40, 8'h80};
  localparam logic [7:0] TV_REG  [NV] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
                                          8'h00, 8'h00, 8'h07, 8'h00,
                                          8'h06, 8'hFA, 8'h06, 8'hFA};
  localparam logic [7:0] TV_EXP  [NV] = '{8'h01, 8'h01, 8'h00, 8'h05, 8'hFB,
                                          8'h00, 8'h00, 8'h07, 8'h00,
                                          8'h01, 8'h00, 8'h01, 8'hFF};
  localparam logic       TV_NAR  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b0, 1'b1, 1'b0, 1'b1,
                                          1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] TV_EXPECT [NV] = '{
    {8'h80, 8'h00, 1'b1, 4'b0000},   // normal
    {8'h40, 8'h02, 1'b0, 4'b0000},   // carry, scale 4
    {8'h00, 8'hFE, 1'b1, 4'b0000},   // scale -3
    {8'h40, 8'h02, 1'b1, 4'b0000},   // large exponent, scale 5
    {8'h80, 8'hFE, 1'b0, 4'b0000},   // negative exponent, scale -4
    {8'h00, 8'h80, 1'b0, 4'b0100},   // zero
    {8'h00, 8'h00, 1'b0, 4'b1000},   // nar
    {8'h00, 8'h80, 1'b0, 4'b0100},   // zero beats would-be overflow
    {8'h00, 8'h00, 1'b0, 4'b1000},   // nar beats zero
    {8'h00, 8'h06, 1'b0, 4'b0010},   // r = 7 overflow
    {8'h00, 8'hFA, 1'b0, 4'b0001},   // r = -9 underflow
    {8'h00, 8'h06, 1'b1, 4'b0000},   // r = 6, no saturation
    {8'h00, 8'hFA, 1'b0, 4'b0000}    // r = -6, no saturation
  };
  localparam int B2B_IDX [6] = '{0, 1, 2, 3, 4, 11};

  logic clk = 1'b0;
  logic rst_n;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  posit_normalise_pipe_if #(.WIDTH(WIDTH), .ES(ES), .RW(RW), .EW(EW)) bus ();

  posit_normalise_pipe #(.WIDTH(WIDTH), .ES(ES), .RW(RW), .EW(EW), .PBITS(PBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [20:0] outputs_now();
    return {bus.out_frac, bus.out_regime, bus.out_exponent,
            bus.out_nar, bus.out_zero, bus.out_ovf, bus.out_unf};
  endfunction

  task automatic drive_vec(input int idx);
    bus.in_mant_sum = TV_MANT[idx];
    bus.in_regime   = TV_REG[idx];
    bus.in_exponent = TV_EXP[idx];
    bus.in_nar      = TV_NAR[idx];
  endtask

  // Sends one beat into an idle pipe and waits (bounded) for its result.
  task automatic send_one(input int idx, output logic [20:0] res, output int cyc);
    @(negedge clk);
    drive_vec(idx);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    res = outputs_now();
    $display("[TB] vec %0d mant=%02h reg=%02h exp=%02h nar=%0d -> frac=%02h reg=%02h exp=%0d nzou=%04b cycles=%0d",
             idx, TV_MANT[idx], TV_REG[idx], TV_EXP[idx], TV_NAR[idx],
             res[20:13], res[12:5], res[4], res[3:0], cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_vec(0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid);
    end
    tests_run++;
    if (outputs_now() !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%06h want=000000", outputs_now());
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready);
    end
    $display("[TB] reset: out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors(input string name, input int first, input int last);
    logic [20:0] res;
    int cyc;
    for (int i = first; i <= last; i++) begin
      send_one(i, res, cyc);
      tests_run++;
      if (cyc !== 2) begin
        tests_failed++;
        $display("FAIL %s_latency vec %0d got=%0d want=2", name, i, cyc);
      end
      tests_run++;
      if (res !== TV_EXPECT[i]) begin
        tests_failed++;
        $display("FAIL %s_result vec %0d got=%06h want=%06h", name, i, res, TV_EXPECT[i]);
      end
    end
  endtask

  task automatic test_normal();
    test_vectors("normal", 0, 4);
  endtask

  task automatic test_zero_nar();
    test_vectors("zero_nar", 5, 8);
  endtask

  task automatic test_saturation();
    test_vectors("saturation", 9, 12);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic saw_stall = 1'b0;
    logic held = 1'b0;
    logic [20:0] held_val = '0;
    while (recv < 6 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 6) begin
        drive_vec(B2B_IDX[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        tests_run++;
        if (outputs_now() !== held_val) begin
          tests_failed++;
          $display("FAIL b2b_stable cycle %0d got=%06h want=%06h", cyc, outputs_now(), held_val);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("[TB] b2b cycle %0d beat %0d out=%06h", cyc, recv, outputs_now());
        tests_run++;
        if (outputs_now() !== TV_EXPECT[B2B_IDX[recv]]) begin
          tests_failed++;
          $display("FAIL b2b_order beat %0d got=%06h want=%06h", recv, outputs_now(),
                   TV_EXPECT[B2B_IDX[recv]]);
        end
        recv++;
        held = 1'b0;
      end else if (bus.out_valid) begin
        held = 1'b1;
        held_val = outputs_now();
      end else begin
        held = 1'b0;
      end
      if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests_run++;
    if (recv !== 6) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d want=6", recv);
    end
    tests_run++;
    if (saw_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_in_ready_stall got=%0b want=1", saw_stall);
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_vec(0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive_vec(1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_prefill got=%0b want=1", bus.out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || outputs_now() !== 21'h0) begin
      tests_failed++;
      $display("FAIL midreset_async got valid=%0b out=%06h want valid=0 out=000000",
               bus.out_valid, outputs_now());
    end
    $display("[TB] midstream reset: out_valid=%0b", bus.out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    tests_run++;
    if (stale !== 0) begin
      tests_failed++;
      $display("FAIL midreset_stale got=%0d want=0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_nar();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
